// File: rtl/pg_uart_csr_pkg.sv
// Shared types and constants for the PG UART CSR bridge: DFH layout,
// feature-local offsets, FSM states and AXI response codes.
package pg_uart_csr_pkg;

    localparam logic [11:0] DFH_OFF     = 12'h000;
    localparam logic [11:0] UART_BASE   = 12'h100;
    localparam logic [11:0] UART_LAST   = 12'h11C;

    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        UART_WR,
        UART_RD,
        WRESP,
        RRESP
    } state_t;

    typedef struct packed {
        logic [3:0]  feat_type;
        logic [18:0] rsvd;
        logic        eol;
        logic [23:0] next_off;
        logic [3:0]  ver;
        logic [11:0] id;
    } dfh_t;

    // True for any byte address inside the 16550 register block,
    // including the unaligned bytes of the last register.
    function automatic logic in_uart_window(input logic [11:0] addr);
        return (addr >= UART_BASE) && (addr <= (UART_LAST + 12'h003));
    endfunction

endpackage

// File: rtl/pg_uart_csr_bridge.sv
// AXI4-Lite CSR slave for the PG UART feature: serves the DFH and forwards
// 16550 register accesses to the UART core over a req/ack byte port, with a
// timeout so a silent core can never stall the host.
module pg_uart_csr_bridge
    import pg_uart_csr_pkg::*;
#(
    parameter logic [11:0] FEAT_ID         = 12'h024,
    parameter logic [3:0]  FEAT_VER        = 4'h0,
    parameter logic [23:0] NEXT_DFH_OFFSET = 24'h0,
    parameter logic        END_OF_LIST     = 1'b1,
    parameter int          TIMEOUT_CYCLES  = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        awvalid,
    output logic        awready,
    input  logic [11:0] awaddr,
    input  logic        wvalid,
    output logic        wready,
    input  logic [63:0] wdata,
    input  logic [7:0]  wstrb,
    output logic        bvalid,
    input  logic        bready,
    output logic [1:0]  bresp,
    input  logic        arvalid,
    output logic        arready,
    input  logic [11:0] araddr,
    output logic        rvalid,
    input  logic        rready,
    output logic [63:0] rdata,
    output logic [1:0]  rresp,
    output logic        uart_req,
    output logic        uart_we,
    output logic [2:0]  uart_addr,
    output logic [7:0]  uart_wdata,
    input  logic        uart_ack,
    input  logic [7:0]  uart_rdata
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             load_uart;
    logic             load_bresp;
    logic             load_rresp;
    logic             uart_we_nxt;
    logic [2:0]       uart_addr_nxt;
    logic [7:0]       uart_wdata_nxt;
    logic [1:0]       resp_nxt;
    logic [63:0]      rdata_nxt;
    logic             lane_strobe;
    logic [7:0]       lane_byte;
    logic             in_uart_state;
    logic             unused_inputs;
    dfh_t             dfh;

    assign dfh = '{feat_type: 4'h3, rsvd: 19'h0, eol: END_OF_LIST,
                   next_off: NEXT_DFH_OFFSET, ver: FEAT_VER, id: FEAT_ID};

    // Each 64-bit beat carries two 32-bit UART registers; addr[2] picks the lane.
    assign lane_strobe   = awaddr[2] ? wstrb[4] : wstrb[0];
    assign lane_byte     = awaddr[2] ? wdata[39:32] : wdata[7:0];
    assign in_uart_state = (state == UART_WR) || (state == UART_RD);
    assign unused_inputs = ^{wdata[63:40], wdata[31:8], wstrb[7:5], wstrb[3:1]};

    // Response valids follow the state directly so the payload registers stay stable.
    assign bvalid = (state == WRESP);
    assign rvalid = (state == RRESP);

    // State register; reset abandons any transaction without a response.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state decode, address handshakes and the UART request strobe.
    always_comb begin
        state_nxt      = state;
        awready        = 1'b0;
        wready         = 1'b0;
        arready        = 1'b0;
        load_uart      = 1'b0;
        load_bresp     = 1'b0;
        load_rresp     = 1'b0;
        uart_we_nxt    = 1'b0;
        uart_addr_nxt  = 3'd0;
        uart_wdata_nxt = 8'd0;
        resp_nxt       = RESP_OKAY;
        rdata_nxt      = 64'd0;
        uart_req       = in_uart_state && !uart_ack;
        case (state)
            IDLE: begin
                if (!rst && awvalid && wvalid) begin
                    awready = 1'b1;
                    wready  = 1'b1;
                    if (in_uart_window(awaddr) && awaddr[1:0] == 2'b00 && lane_strobe) begin
                        state_nxt      = UART_WR;
                        load_uart      = 1'b1;
                        uart_we_nxt    = 1'b1;
                        uart_addr_nxt  = awaddr[4:2];
                        uart_wdata_nxt = lane_byte;
                    end else begin
                        state_nxt  = WRESP;
                        load_bresp = 1'b1;
                        if (in_uart_window(awaddr) && awaddr[1:0] != 2'b00)
                            resp_nxt = RESP_SLVERR;
                    end
                end else if (!rst && arvalid) begin
                    arready = 1'b1;
                    if (in_uart_window(araddr) && araddr[1:0] == 2'b00) begin
                        state_nxt     = UART_RD;
                        load_uart     = 1'b1;
                        uart_addr_nxt = araddr[4:2];
                    end else begin
                        state_nxt  = RRESP;
                        load_rresp = 1'b1;
                        if (in_uart_window(araddr))
                            resp_nxt = RESP_SLVERR;
                        else if (araddr == DFH_OFF)
                            rdata_nxt = dfh;
                    end
                end
            end
            UART_WR: begin
                if (uart_ack) begin
                    state_nxt  = WRESP;
                    load_bresp = 1'b1;
                end else if (cnt == CNT_LAST) begin
                    state_nxt  = WRESP;
                    load_bresp = 1'b1;
                    resp_nxt   = RESP_SLVERR;
                end
            end
            UART_RD: begin
                if (uart_ack) begin
                    state_nxt  = RRESP;
                    load_rresp = 1'b1;
                    rdata_nxt  = {24'h0, uart_rdata, 24'h0, uart_rdata};
                end else if (cnt == CNT_LAST) begin
                    state_nxt  = RRESP;
                    load_rresp = 1'b1;
                    resp_nxt   = RESP_SLVERR;
                    rdata_nxt  = {64{1'b1}};
                end
            end
            WRESP: begin
                if (bready) state_nxt = IDLE;
            end
            RRESP: begin
                if (rready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Payload registers and the ack timeout counter, cleared on every UART entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= '0;
            bresp      <= RESP_OKAY;
            rresp      <= RESP_OKAY;
            rdata      <= 64'd0;
            uart_we    <= 1'b0;
            uart_addr  <= 3'd0;
            uart_wdata <= 8'd0;
        end else begin
            if (load_uart) begin
                cnt        <= '0;
                uart_we    <= uart_we_nxt;
                uart_addr  <= uart_addr_nxt;
                uart_wdata <= uart_wdata_nxt;
            end else if (in_uart_state) begin
                cnt <= cnt + 1'b1;
            end
            if (load_bresp) bresp <= resp_nxt;
            if (load_rresp) begin
                rresp <= resp_nxt;
                rdata <= rdata_nxt;
            end
        end
    end

endmodule

// File: tb/tb_pg_uart_csr_bridge.sv
// Directed bench for pg_uart_csr_bridge: expected responses are queued when a
// transaction is issued and checked when the bridge raises bvalid/rvalid.
module tb_pg_uart_csr_bridge;

    localparam logic [1:0]  TB_OKAY   = 2'b00;
    localparam logic [1:0]  TB_SLVERR = 2'b10;
    localparam logic [63:0] DFH_EXP   = 64'h3000_0100_0000_0024;

    typedef struct {
        logic        is_read;
        logic [1:0]  resp;
        logic [63:0] data;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        awvalid, awready, wvalid, wready;
    logic [11:0] awaddr, araddr;
    logic [63:0] wdata, rdata;
    logic [7:0]  wstrb;
    logic        bvalid, bready, arvalid, arready, rvalid, rready;
    logic [1:0]  bresp, rresp;
    logic        uart_req, uart_we, uart_ack;
    logic [2:0]  uart_addr;
    logic [7:0]  uart_wdata, uart_rdata;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;

    logic       ack_enable = 1'b0;
    int         ack_delay  = 1;
    logic [7:0] ack_data   = 8'h00;
    int         req_high   = 0;
    int         req_cycles = 0;
    logic       seen_we    = 1'b0;
    logic [2:0] seen_addr  = 3'd0;
    logic [7:0] seen_wdata = 8'd0;

    pg_uart_csr_bridge #(.TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst(rst),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
        .bvalid(bvalid), .bready(bready), .bresp(bresp),
        .arvalid(arvalid), .arready(arready), .araddr(araddr),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
        .uart_req(uart_req), .uart_we(uart_we), .uart_addr(uart_addr),
        .uart_wdata(uart_wdata), .uart_ack(uart_ack), .uart_rdata(uart_rdata)
    );

    // Free-running CSR clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard time limit so a stuck bridge cannot hang the run.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // UART core model: acks after ack_delay request cycles and records the request.
    initial begin
        uart_ack   = 1'b0;
        uart_rdata = 8'h00;
        forever begin
            @(negedge clk);
            #1;
            if (uart_ack) begin
                uart_ack   = 1'b0;
                req_cycles = 0;
            end else if (uart_req) begin
                req_high++;
                req_cycles++;
                if (ack_enable && req_cycles >= ack_delay) begin
                    uart_ack   = 1'b1;
                    uart_rdata = ack_data;
                    seen_we    = uart_we;
                    seen_addr  = uart_addr;
                    seen_wdata = uart_wdata;
                end
            end else begin
                req_cycles = 0;
            end
        end
    end

    function automatic exp_t mkExp(input logic is_read, input logic [1:0] resp, input logic [63:0] data);
        exp_t e;
        e.is_read = is_read;
        e.resp    = resp;
        e.data    = data;
        return e;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic stepCycle();
        @(negedge clk);
        #1;
    endtask

    task automatic applyStimulus(input string tag, input logic is_write, input logic [11:0] addr,
                                 input logic [63:0] data, input logic [7:0] strb, input exp_t e);
        int   n = 0;
        logic ready;
        sb.push_back(e);
        if (is_write) begin
            awaddr  = addr;
            wdata   = data;
            wstrb   = strb;
            awvalid = 1'b1;
            wvalid  = 1'b1;
        end else begin
            araddr  = addr;
            arvalid = 1'b1;
        end
        #1;
        ready = is_write ? (awready && wready) : arready;
        while (!ready && n < 20) begin
            stepCycle();
            ready = is_write ? (awready && wready) : arready;
            n++;
        end
        checkOutput({tag, "_accept"}, 64'(ready), 64'd1);
        if (ready) stepCycle();
        awvalid = 1'b0;
        wvalid  = 1'b0;
        arvalid = 1'b0;
    endtask

    task automatic waitResponse(input string tag, input int hold);
        exp_t e;
        int   n = 0;
        e = mkExp(1'b0, TB_OKAY, 64'd0);
        while (!(bvalid || rvalid) && n < 200) begin
            stepCycle();
            n++;
        end
        if (sb.size() > 0) e = sb.pop_front();
        checkOutput({tag, "_seen"}, 64'(bvalid || rvalid), 64'd1);
        if (!(bvalid || rvalid)) return;
        for (int i = 0; i <= hold; i++) begin
            checkOutput({tag, "_kind"}, 64'({rvalid, bvalid}), e.is_read ? 64'd2 : 64'd1);
            checkOutput({tag, "_resp"}, e.is_read ? 64'(rresp) : 64'(bresp), 64'(e.resp));
            if (e.is_read) checkOutput({tag, "_data"}, rdata, e.data);
            if (i < hold) stepCycle();
        end
        bready = 1'b1;
        rready = 1'b1;
        stepCycle();
        bready = 1'b0;
        rready = 1'b0;
        checkOutput({tag, "_done"}, 64'({rvalid, bvalid}), 64'd0);
    endtask

    // Directed sequence covering DFH, UART forwarding, timeout, arbitration and reset.
    initial begin
        rst = 1'b1;
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        awaddr = 12'h0; araddr = 12'h0; wdata = 64'h0; wstrb = 8'h0;
        bready = 1'b0; rready = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checkOutput("reset_hs", 64'({awready, wready, arready, bvalid, rvalid}), 64'd0);
        checkOutput("reset_uart", 64'({uart_req, uart_we, uart_addr, uart_wdata}), 64'd0);
        checkOutput("reset_resp", 64'({bresp, rresp}), 64'd0);
        checkOutput("reset_rdata", rdata, 64'd0);
        rst = 1'b0;
        stepCycle();

        applyStimulus("dfh", 1'b0, 12'h000, 64'd0, 8'd0, mkExp(1'b1, TB_OKAY, DFH_EXP));
        checkOutput("dfh_latency", 64'(rvalid), 64'd1);
        waitResponse("dfh", 0);

        ack_enable = 1'b1;
        ack_delay  = 3;
        applyStimulus("wr10c", 1'b1, 12'h10C, 64'h0000_0083_0000_00EE, 8'h10, mkExp(1'b0, TB_OKAY, 64'd0));
        waitResponse("wr10c", 0);
        checkOutput("wr10c_we", 64'(seen_we), 64'd1);
        checkOutput("wr10c_addr", 64'(seen_addr), 64'd3);
        checkOutput("wr10c_wdata", 64'(seen_wdata), 64'h83);

        ack_delay = 1;
        ack_data  = 8'h60;
        applyStimulus("rd114", 1'b0, 12'h114, 64'd0, 8'd0, mkExp(1'b1, TB_OKAY, 64'h0000_0060_0000_0060));
        waitResponse("rd114", 0);
        checkOutput("rd114_we", 64'(seen_we), 64'd0);
        checkOutput("rd114_addr", 64'(seen_addr), 64'd5);

        ack_enable = 1'b0;
        req_high   = 0;
        applyStimulus("tmo", 1'b0, 12'h100, 64'd0, 8'd0, mkExp(1'b1, TB_SLVERR, {64{1'b1}}));
        waitResponse("tmo", 0);
        checkOutput("tmo_req_cycles", 64'(req_high), 64'd16);

        ack_enable = 1'b1;
        ack_delay  = 2;
        sb.push_back(mkExp(1'b0, TB_OKAY, 64'd0));
        sb.push_back(mkExp(1'b1, TB_OKAY, DFH_EXP));
        awaddr = 12'h104; wdata = 64'h0000_005A_0000_0011; wstrb = 8'hFF;
        araddr = 12'h000;
        awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
        #1;
        checkOutput("both_awready", 64'({awready, wready}), 64'd3);
        checkOutput("both_arready", 64'(arready), 64'd0);
        stepCycle();
        awvalid = 1'b0;
        wvalid  = 1'b0;
        waitResponse("both_wr", 5);
        checkOutput("both_wr_addr", 64'(seen_addr), 64'd1);
        checkOutput("both_wr_wdata", 64'(seen_wdata), 64'h5A);
        checkOutput("both_rd_accept", 64'(arready), 64'd1);
        stepCycle();
        arvalid = 1'b0;
        waitResponse("both_rd", 0);

        req_high = 0;
        applyStimulus("rd102", 1'b0, 12'h102, 64'd0, 8'd0, mkExp(1'b1, TB_SLVERR, 64'd0));
        waitResponse("rd102", 0);
        applyStimulus("wr108", 1'b1, 12'h108, 64'h0000_0077_0000_0077, 8'hF0, mkExp(1'b0, TB_OKAY, 64'd0));
        waitResponse("wr108", 0);
        checkOutput("no_uart_access", 64'(req_high), 64'd0);
        applyStimulus("wr000", 1'b1, 12'h000, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, mkExp(1'b0, TB_OKAY, 64'd0));
        waitResponse("wr000", 0);
        applyStimulus("rd040", 1'b0, 12'h040, 64'd0, 8'd0, mkExp(1'b1, TB_OKAY, 64'd0));
        waitResponse("rd040", 0);
        applyStimulus("rd120", 1'b0, 12'h120, 64'd0, 8'd0, mkExp(1'b1, TB_OKAY, 64'd0));
        waitResponse("rd120", 0);

        ack_enable = 1'b0;
        applyStimulus("rst_rd", 1'b0, 12'h100, 64'd0, 8'd0, mkExp(1'b1, TB_SLVERR, {64{1'b1}}));
        stepCycle();
        stepCycle();
        checkOutput("rst_req_before", 64'(uart_req), 64'd1);
        rst = 1'b1;
        stepCycle();
        checkOutput("rst_req_after", 64'(uart_req), 64'd0);
        checkOutput("rst_rvalid_after", 64'(rvalid), 64'd0);
        rst = 1'b0;
        sb.delete();
        stepCycle();
        applyStimulus("dfh2", 1'b0, 12'h000, 64'd0, 8'd0, mkExp(1'b1, TB_OKAY, DFH_EXP));
        waitResponse("dfh2", 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
